// File: rtl/sr04_pkg.sv
// rtl/sr04_pkg.sv - shared SR04 state encoding, distance constants and width helper
package sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_DELAY   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } sr04_state_e;

  localparam int US_PER_CM  = 58;
  localparam int MAX_CM     = 400;
  localparam int TIMEOUT_US = 38000;
  localparam int WIDTH_W    = 17;

  // 0 cm or beyond range reads as "no object" and gets the timeout width
  function automatic logic [WIDTH_W-1:0] echo_width_us(
    input logic [8:0] dist_cm,
    input int         us_per_cm,
    input int         max_cm,
    input int         timeout_us
  );
    int d;
    d = int'(dist_cm);
    if (d == 0 || d > max_cm)
      return WIDTH_W'(timeout_us);
    return WIDTH_W'(d * us_per_cm);
  endfunction

endpackage

// File: rtl/sr04_us_tick.sv
// rtl/sr04_us_tick.sv - free-running prescaler producing a one-clk tick every TICK_DIV clks
module sr04_us_tick #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      o_tick  <= 1'b0;
    end else if (div_cnt == CW'(TICK_DIV - 1)) begin
      div_cnt <= '0;
      o_tick  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
      o_tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/sr04_echo_emulator.sv
// rtl/sr04_echo_emulator.sv - HC-SR04 sensor-side trigger/echo emulator
// Optional SR04_EMU_NOISE_EN adds 0..7 us LFSR jitter to every echo width.
module sr04_echo_emulator
  import sr04_pkg::*;
#(
  parameter int TICK_DIV      = 100,
  parameter int MIN_TRIG_US   = 10,
  parameter int ECHO_DELAY_US = 200,
  parameter int CM_TO_US      = US_PER_CM,
  parameter int MAX_DIST_CM   = MAX_CM,
  parameter int NO_OBJ_US     = TIMEOUT_US,
  parameter int HOLDOFF_US    = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_trigger,
  input  logic [8:0] i_distance_cm,
  output logic       o_echo,
  output logic       o_busy,
  output logic       o_trig_err
);

  logic                 tick;
  logic                 trig_s1;
  logic                 trig_s2;
  logic                 trig_d;
  logic                 trig_rise;
  logic                 trig_fall;
  sr04_state_e          state;
  sr04_state_e          state_next;
  logic [WIDTH_W-1:0]   cnt;
  logic [WIDTH_W-1:0]   cnt_next;
  logic [WIDTH_W-1:0]   width;
  logic [WIDTH_W-1:0]   width_next;
  logic [WIDTH_W-1:0]   new_width;
  logic                 accept;
  logic                 err_next;
  logic                 echo_next;

  sr04_us_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .o_tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      trig_s1 <= i_trigger;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
    end
  end

  assign trig_rise = trig_s2 & ~trig_d;
  assign trig_fall = ~trig_s2 & trig_d;

`ifdef SR04_EMU_NOISE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign new_width = echo_width_us(i_distance_cm, CM_TO_US, MAX_DIST_CM, NO_OBJ_US)
                     + WIDTH_W'(lfsr[2:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (accept)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign new_width = echo_width_us(i_distance_cm, CM_TO_US, MAX_DIST_CM, NO_OBJ_US);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      width <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      width <= width_next;
    end
  end

  // Edges seen outside IDLE/TRIG_HI fall through untouched, so late triggers are ignored
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    width_next = width;
    err_next   = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_rise) begin
          state_next = ST_TRIG_HI;
          cnt_next   = '0;
        end
      end
      ST_TRIG_HI: begin
        if (trig_fall) begin
          cnt_next = '0;
          if (cnt >= WIDTH_W'(MIN_TRIG_US - 1)) begin
            accept     = 1'b1;
            width_next = new_width;
            state_next = ST_DELAY;
          end else begin
            err_next   = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (tick && cnt != '1) begin
          cnt_next = cnt + WIDTH_W'(1);
        end
      end
      ST_DELAY: begin
        if (tick) begin
          if (cnt == WIDTH_W'(ECHO_DELAY_US - 1)) begin
            cnt_next   = '0;
            state_next = ST_ECHO;
          end else begin
            cnt_next = cnt + WIDTH_W'(1);
          end
        end
      end
      ST_ECHO: begin
        if (tick) begin
          if (cnt == width - WIDTH_W'(1)) begin
            cnt_next   = '0;
            state_next = ST_HOLDOFF;
          end else begin
            cnt_next = cnt + WIDTH_W'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (tick) begin
          if (cnt == WIDTH_W'(HOLDOFF_US - 1)) begin
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt + WIDTH_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Echo follows the registered state, so both edges sit on tick boundaries
  always_comb begin
    echo_next = (state_next == ST_ECHO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_echo     <= 1'b0;
      o_trig_err <= 1'b0;
    end else begin
      o_echo     <= echo_next;
      o_trig_err <= err_next;
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// tb/tb_sr04_echo_emulator.sv - scoreboard bench for sr04_echo_emulator (scaled timing)
module tb_sr04_echo_emulator;

  localparam int TD     = 2;
  localparam int MIN_US = 10;
  localparam int DLY_US = 20;
  localparam int UPC    = 3;
  localparam int MAXC   = 400;
  localparam int TO_US  = 1500;
  localparam int HO_US  = 100;
`ifdef SR04_EMU_NOISE_EN
  localparam int JMAX = 7;
`else
  localparam int JMAX = 0;
`endif

  typedef struct {
    bit is_err;
    int lo;
    int hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_trigger;
  logic [8:0] i_distance_cm;
  logic       o_echo;
  logic       o_busy;
  logic       o_trig_err;

  exp_t sb[$];
  int   widths[$];
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   rise_cyc = 0;
  bit   in_echo = 1'b0;

  sr04_echo_emulator #(
    .TICK_DIV     (TD),
    .MIN_TRIG_US  (MIN_US),
    .ECHO_DELAY_US(DLY_US),
    .CM_TO_US     (UPC),
    .MAX_DIST_CM  (MAXC),
    .NO_OBJ_US    (TO_US),
    .HOLDOFF_US   (HO_US)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_trigger    (i_trigger),
    .i_distance_cm(i_distance_cm),
    .o_echo       (o_echo),
    .o_busy       (o_busy),
    .o_trig_err   (o_trig_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input int act, input int lo, input int hi);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   w;
    int   dl;
    if (rst) begin
      in_echo = 1'b0;
    end else begin
      if (o_echo && !in_echo) begin
        in_echo  = 1'b1;
        rise_cyc = cyc;
        dl = cyc - fall_cyc;
        chk("echo_delay", dl >= (DLY_US - 1) * TD && dl <= (DLY_US + 1) * TD + 4,
            dl, (DLY_US - 1) * TD, (DLY_US + 1) * TD + 4);
      end else if (!o_echo && in_echo) begin
        in_echo = 1'b0;
        w = cyc - rise_cyc;
        widths.push_back(w);
        if (sb.size() == 0) begin
          chk("unexpected_echo", 1'b0, w, 0, 0);
        end else begin
          e = sb.pop_front();
          chk("echo_width", !e.is_err && w >= e.lo && w <= e.hi, w, e.lo, e.hi);
        end
      end
      if (o_trig_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_trig_err", 1'b0, 1, 0, 0);
        end else begin
          e = sb.pop_front();
          chk("trig_err_expected", e.is_err, 1, e.lo, e.hi);
        end
      end
    end
  end

  task automatic push_echo(input int w_us);
    exp_t e;
    e.is_err = 1'b0;
    e.lo     = w_us * TD;
    e.hi     = (w_us + JMAX) * TD;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.lo     = -1;
    e.hi     = -1;
    sb.push_back(e);
  endtask

  task automatic pulse(input int us);
    @(posedge clk);
    #2 i_trigger = 1'b1;
    repeat (us * TD) @(posedge clk);
    #2 i_trigger = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, !o_busy, int'(o_busy), 0, 0);
  endtask

  task automatic wait_echo(input logic level, input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (o_echo !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, o_echo === level, int'(o_echo), int'(level), int'(level));
  endtask

  initial begin
    int ndiff;
    rst = 1'b1;
    i_trigger = 1'b0;
    i_distance_cm = 9'd10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_echo", o_echo == 1'b0, int'(o_echo), 0, 0);
    chk("reset_busy", o_busy == 1'b0, int'(o_busy), 0, 0);
    chk("reset_trig_err", o_trig_err == 1'b0, int'(o_trig_err), 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);

    // d=10 -> 30 us
    push_echo(30);
    pulse(12);
    wait_busy_low("t1_idle", 2000);

    // short trigger rejected
    push_err();
    pulse(5);
    wait_busy_low("t2_idle", 200);
    chk("t2_echo_low", o_echo == 1'b0, int'(o_echo), 0, 0);

    // no-object and max-range widths
    i_distance_cm = 9'd0;
    push_echo(TO_US);
    pulse(12);
    wait_busy_low("t3_d0_idle", 5000);
    i_distance_cm = 9'd450;
    push_echo(TO_US);
    pulse(12);
    wait_busy_low("t3_d450_idle", 5000);
    i_distance_cm = 9'd400;
    push_echo(400 * UPC);
    pulse(12);
    wait_busy_low("t3_d400_idle", 5000);

    // triggers during ECHO and HOLDOFF are ignored, distance change after latch too
    i_distance_cm = 9'd10;
    push_echo(30);
    pulse(12);
    wait_echo(1'b1, "t4_echo_rise", 500);
    i_distance_cm = 9'd200;
    pulse(12);
    wait_echo(1'b0, "t4_echo_fall", 500);
    repeat (20) @(posedge clk);
    pulse(12);
    chk("t4_busy_in_holdoff", o_busy == 1'b1, int'(o_busy), 1, 1);
    wait_busy_low("t4_idle", 1000);
    i_distance_cm = 9'd10;
    push_echo(30);
    pulse(12);
    wait_busy_low("t4_rearm_idle", 2000);

    // reset mid-echo
    pulse(12);
    wait_echo(1'b1, "t5_echo_rise", 500);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t5_echo_async_low", o_echo == 1'b0, int'(o_echo), 0, 0);
    chk("t5_busy_low", o_busy == 1'b0, int'(o_busy), 0, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    push_echo(30);
    pulse(12);
    wait_busy_low("t5_after_rst_idle", 2000);

    // eight back-to-back echoes, jitter spread when noise is built in
    widths.delete();
    for (int k = 0; k < 8; k++) begin
      push_echo(30);
      pulse(12);
      wait_busy_low("t6_idle", 2000);
    end
    chk("t6_count", widths.size() == 8, widths.size(), 8, 8);
    ndiff = 0;
    if (widths.size() > 0)
      foreach (widths[k]) if (widths[k] != widths[0]) ndiff++;
`ifdef SR04_EMU_NOISE_EN
    chk("t6_widths_vary", ndiff > 0, ndiff, 1, 7);
`else
    chk("t6_widths_equal", ndiff == 0, ndiff, 0, 0);
`endif

    repeat (5) @(posedge clk);
    chk("sb_drained", sb.size() == 0, sb.size(), 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
